sng_stream: RTL
===============

# sng_stream

Stochastic number generator stage directly downstream of `taus88_opt`. It consumes the free-running 32-bit `rnd` word and emits a unipolar stochastic bitstream of programmable length, with P(bit=1) = `prob`/2^PROB_W. Downstream stochastic arithmetic pulls bits through a valid/ready handshake. The block reports the count of ones at stream end for self-check and decode.

## Interface
- PROB_W, 16: probability width; compared against `rnd[31 -: PROB_W]`; legal range 1..32.
- LEN_W, 16: stream-length and ones-counter width.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rnd  in  32  random word from `taus88_opt`; a new word is valid every cycle.
- start  in  1  request a new stream; sampled only in IDLE.
- prob  in  PROB_W  probability numerator; latched on an accepted start.
- len  in  LEN_W  number of bits in the stream; latched on an accepted start.
- bit_out  out  1  current stochastic bit.
- bit_valid  out  1  `bit_out` holds an untransferred bit.
- bit_ready  in  1  downstream accepts `bit_out` this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last bit transfers.
- ones_count  out  LEN_W  ones transferred in the current or last stream.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: emits bits.
  - DONE: one cycle, then back to IDLE.
- IDLE with `start`=1:
  - Latch `prob` into prob_q and `len` into remaining.
  - Clear `ones_count`.
  - If `len`≠0: load `bit_out` ← (`rnd[31 -: PROB_W]` < `prob`), using `rnd` of the same cycle; go to RUN.
  - If `len`=0: emit no bits; go to DONE.
- RUN, transfer cycle (`bit_valid` && `bit_ready`):
  - `ones_count` += `bit_out`.
  - remaining −= 1.
  - If remaining was 1: go to DONE.
  - Otherwise: `bit_out` ← (`rnd[31 -: PROB_W]` < prob_q), using the current `rnd`.
- RUN with `bit_ready`=0: `bit_out` and `bit_valid` hold. `rnd` words during the stall are discarded; this is acceptable because taus88 words are independent.
- Comparison is unsigned with strict less-than:
  - `prob`=0 always yields 0.
  - Maximum P(1) = (2^PROB_W−1)/2^PROB_W.
- `ones_count` saturates at 2^LEN_W−1. This cannot happen for a legal stream, since ones ≤ len ≤ 2^LEN_W−1.
- `start` is ignored in RUN and DONE. It has no queueing and no error flag.
- `prob` and `len` changes outside an accepted start have no effect.

## Timing
- Reset values:
  - State IDLE.
  - `bit_out`=0, `bit_valid`=0, `busy`=0, `done`=0, `ones_count`=0.
  - Internal prob_q=0, remaining=0.
- Reset mid-stream aborts immediately: no `done` pulse, and the partial `ones_count` is cleared.
- Start latency: `start` accepted in cycle N → `bit_valid`=1 and `busy`=1 in cycle N+1.
- Throughput: 1 bit/cycle with `bit_ready` held high.
- Stream length L≥1 with `bit_ready` held high from N+1:
  - Last transfer in cycle N+L.
  - `done`=1 and `busy`=0 in N+L+1.
  - IDLE in N+L+2, where a new start is accepted.
- Stream length L=0: `done` in N+1; `bit_valid` never asserts.
- `bit_valid` drops in the cycle after the last transfer.
- `ones_count` is final when `done` is high and holds until the next accepted start.
- `rnd` is sampled combinationally in the load cycle. No extra register stage sits between `taus88_opt` and the comparator.

## Structure
- Shared package `sng_pkg`:
  - State enum `sng_state_t` {IDLE, RUN, DONE}.
  - Default PROB_W/LEN_W constants.
  - `RND_W`=32, reused by other RNG consumers.
- No sub-module. The comparator and counters are inline. A second consumer of the same comparator later justifies factoring out `sng_cmp`.

## Test plan
The bench drives `rnd` directly for determinism. An optional final run chains `taus88_opt`.

- `prob`=0, `len`=8, `rnd`=0x0000_0000 constant, `bit_ready`=1 → 8 bits all 0; `done` at start+9; `ones_count`=0.
- `rnd`=0x8000_0000 constant, `len`=4:
  - `prob`=0x8000 → all bits 0, `ones_count`=0.
  - `prob`=0x8001 → all bits 1, `ones_count`=4.
- `rnd` incrementing its top 16 bits 0x0000..0xFFFF per cycle, `prob`=0x4000, `len`=65535, `bit_ready`=1 → `ones_count`=16384 at `done`.
- `len`=6, `prob`=0x8001, `rnd`=0x8000_0000, `bit_ready` low for 3 cycles mid-stream → `bit_out`/`bit_valid` stable during the stall; exactly 6 transfers; `ones_count`=6; `done` 3 cycles later than the unstalled case.
- Edge cases:
  - `len`=0 → `done` in N+1 with no `bit_valid`.
  - `start` during RUN → ignored; the stream completes with the original `len`/`prob`.
  - `rst` at the 3rd bit of a 10-bit stream → next cycle all outputs 0 and IDLE; a new start works normally.
- Chained with `taus88_opt` (seed 0xDEADBEEF), `prob`=0x8000, `len`=4096 → `ones_count` within 2048±128.

Source files
------------

// File: rtl/sng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sng_pkg
//  Description : Shared types and constants for the stochastic number
//                generator and other consumers of the taus88 RNG word.
//  Revision    : 1.0 - initial release
// ============================================================================
package sng_pkg;

    localparam int RND_W      = 32;
    localparam int DEF_PROB_W = 16;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sng_state_t;

endpackage
`default_nettype wire

// File: rtl/sng_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sng_stream
//  Description : Unipolar stochastic bitstream generator with valid/ready
//                output and end-of-stream ones count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sng_stream
    import sng_pkg::*;
#(
    parameter int PROB_W = DEF_PROB_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RND_W-1:0]  rnd,
    input  logic              start,
    input  logic [PROB_W-1:0] prob,
    input  logic [LEN_W-1:0]  len,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  ones_count
);

    sng_state_t        r_state;
    logic [PROB_W-1:0] r_prob_q;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_ones_count;
    logic              r_bit_out;
    logic              r_bit_valid;
    logic              r_busy;
    logic              r_done;

    logic [PROB_W-1:0] w_rnd_top;
    logic              w_load_bit;
    logic              w_next_bit;
    logic              w_xfer;
    logic              w_unused_rnd;

    // Low rnd bits below the comparator window are intentionally ignored.
    assign w_rnd_top    = rnd[RND_W-1 -: PROB_W];
    assign w_unused_rnd = ^rnd;
    assign w_load_bit   = (w_rnd_top < prob);
    assign w_next_bit   = (w_rnd_top < r_prob_q);
    assign w_xfer       = r_bit_valid && bit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_prob_q     <= '0;
            r_remaining  <= '0;
            r_ones_count <= '0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_prob_q     <= prob;
                        r_remaining  <= len;
                        r_ones_count <= '0;
                        if (len != '0) begin
                            r_bit_out   <= w_load_bit;
                            r_bit_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        if (r_bit_out && (r_ones_count != '1))
                            r_ones_count <= r_ones_count + LEN_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_bit_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_bit_out <= w_next_bit;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ones_count = r_ones_count;

endmodule
`default_nettype wire
